entropy_source_select: RTL and testbench
========================================

# entropy_source_select

Selects one of four entropy lanes, one of which is an internal deterministic alternating-bit test source, and forwards the chosen bit/valid pair downstream. It also emits a one-cycle pulse whenever the lane selector changes, so downstream debiasing and collection logic can flush stale state. The block sits between the raw entropy generators (ring oscillator, repeating source, user input) and the Von Neumann unbiaser / vector buffer in the TRNG top.

## Interface
- `ALT_LANE`, default 1: lane index (0..3) driven by the internal alternating source; the external inputs for that lane are ignored.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `src_bit`  in  4  external entropy bit per lane; bit i belongs to lane i.
- `src_valid`  in  4  external valid per lane; bit i belongs to lane i.
- `sel`  in  2  lane selector.
- `ent_bit`  out  1  selected entropy bit.
- `ent_valid`  out  1  selected valid, masked during a selector change.
- `src_changed`  out  1  one-cycle pulse after a selector change.
- `alt_bit`  out  1  internal alternator bit, for observation.

## Operation
- **Alternator:**
  - On reset: `alt_bit`=0 and alt_valid=0.
  - Every non-reset edge: alt_valid←1 and `alt_bit`←~`alt_bit`.
  - Lane `ALT_LANE` uses {alt_bit, alt_valid} in place of `src_bit`/`src_valid`.
- **Mux:**
  - Purely combinational, zero latency.
  - Muxed bit = lane[`sel`] bit; muxed valid = lane[`sel`] valid.
  - `ent_bit` = muxed bit.
  - `ent_valid` = muxed valid & ~`src_changed`.
- **Change detector:**
  - Registers: sel_q (2 bits), primed (1 bit), `src_changed`.
  - On reset: sel_q=0, primed=0, `src_changed`=0.
  - Every non-reset edge: `src_changed`←primed & (`sel`≠sel_q); sel_q←`sel`; primed←1.
  - The first edge after reset captures `sel` and produces no pulse, even if `sel`≠0.
- All four `sel` values are legal; there is no illegal encoding.

## Timing
- Reset values: `alt_bit`=0, `src_changed`=0, `ent_valid`=0 when lane `ALT_LANE` is selected; other lanes pass their inputs combinationally during reset.
- Alternator after reset release, at edges 1, 2, 3, …: `alt_bit` = 1, 0, 1, …; alt_valid = 1 from edge 1 onward.
- Selector change:
  - `sel` changes between edge N-1 and edge N.
  - `ent_bit` follows the new lane immediately (same cycle, combinational).
  - `src_changed`=1 for exactly the cycle after edge N; `ent_valid` is forced 0 in that cycle.
- Back-to-back changes on consecutive edges give consecutive pulses; `src_changed` stays high while `sel` changes every cycle.
- A change that reverts before the next edge (glitch between edges) is not seen and gives no pulse.
- Reset mid-operation: all registers return to reset values at that edge. Any pending pulse is dropped, and the first post-reset edge re-arms the detector without pulsing.

## Structure
- Shared package `trng_pkg`:
  - `NUM_LANES`=4 and `SEL_W`=2.
  - Lane index constants `LANE_RO`=0, `LANE_ALT`=1, `LANE_REP`=2, `LANE_USER`=3.
  - A `lane_sel_t` 2-bit typedef.
- One natural sub-module: `alternating_rng` (clk, rst → alt_bit, alt_valid).
- Mux and change detector stay inline in the top.

## Test plan
- Reset, then release with `sel`=1 → `ent_valid`=0 during reset. After release `ent_valid`=1 and `ent_bit` = 1, 0, 1, 0 on edges 1–4; `src_changed` stays 0.
- `sel`=0, `src_bit`=4'b0001, `src_valid`=4'b0001, then `sel`=3 with `src_valid`=4'b1000 and `src_bit`=4'b1000 → `ent_bit`=1 throughout. Exactly one cycle with `src_changed`=1 and `ent_valid`=0, then `ent_valid`=1.
- Hold `sel`=2 at reset release → no pulse on the first edge; `src_changed`=0 forever while `sel` is constant.
- `sel` stepped 0→1→2→3 on consecutive edges → `src_changed` high for 3 consecutive cycles, then low.
- `sel` changes, and `rst` is asserted on the next edge → `src_changed`=0 after reset. The first post-reset edge gives no pulse; `alt_bit` restarts at 0.
- `sel`=1 with `src_bit[1]`=1 and `src_valid[1]`=0 → outputs track the alternator; the lane-1 external inputs have no effect.

Source files
------------

// File: rtl/trng_pkg.sv
// Shared TRNG definitions: lane count, selector width and lane index assignments.
package trng_pkg;

  localparam int unsigned NUM_LANES = 4;
  localparam int unsigned SEL_W     = 2;

  typedef logic [SEL_W-1:0] lane_sel_t;

  localparam lane_sel_t LANE_RO   = 2'd0;
  localparam lane_sel_t LANE_ALT  = 2'd1;
  localparam lane_sel_t LANE_REP  = 2'd2;
  localparam lane_sel_t LANE_USER = 2'd3;

endpackage

// File: rtl/alternating_rng.sv
// Deterministic test source: 0101... bit stream, valid from the first edge after reset.
module alternating_rng (
  input  logic clk,
  input  logic rst,
  output logic alt_bit,
  output logic alt_valid
);

  logic alt_bit_d, alt_valid_d;

  always_comb begin
    alt_bit_d   = ~alt_bit;
    alt_valid_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alt_bit   <= 1'b0;
      alt_valid <= 1'b0;
    end else begin
      alt_bit   <= alt_bit_d;
      alt_valid <= alt_valid_d;
    end
  end

endmodule

// File: rtl/entropy_source_select.sv
// Four-lane entropy mux with an internal alternating lane and a selector-change pulse
// that masks the forwarded valid for one cycle.
module entropy_source_select
  import trng_pkg::*;
#(
  parameter int unsigned ALT_LANE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_LANES-1:0] src_bit,
  input  logic [NUM_LANES-1:0] src_valid,
  input  lane_sel_t            sel,
  output logic                 ent_bit,
  output logic                 ent_valid,
  output logic                 src_changed,
  output logic                 alt_bit
);

  localparam lane_sel_t AltIdx = lane_sel_t'(ALT_LANE);

  logic                 alt_valid;
  logic [NUM_LANES-1:0] lane_bit, lane_valid;
  lane_sel_t            sel_q, sel_d;
  logic                 primed_q, primed_d;
  logic                 src_changed_d;

  alternating_rng u_alternating_rng (
    .clk       (clk),
    .rst       (rst),
    .alt_bit   (alt_bit),
    .alt_valid (alt_valid)
  );

  always_comb begin
    lane_bit           = src_bit;
    lane_valid         = src_valid;
    lane_bit[AltIdx]   = alt_bit;
    lane_valid[AltIdx] = alt_valid;
  end

  assign ent_bit   = lane_bit[sel];
  assign ent_valid = lane_valid[sel] & ~src_changed;

  // The primed flag suppresses a pulse on the first edge, when sel_q is not yet meaningful.
  always_comb begin
    src_changed_d = primed_q & (sel != sel_q);
    sel_d         = sel;
    primed_d      = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q       <= '0;
      primed_q    <= 1'b0;
      src_changed <= 1'b0;
    end else begin
      sel_q       <= sel_d;
      primed_q    <= primed_d;
      src_changed <= src_changed_d;
    end
  end

endmodule

// File: tb/tb_entropy_source_select.sv
// Directed self-checking bench for entropy_source_select.
module tb_entropy_source_select;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] src_bit;
  logic [3:0] src_valid;
  logic [1:0] sel;
  logic       ent_bit, ent_valid, src_changed, alt_bit;

  int checks = 0;
  int errors = 0;

  // Reference alternator, advanced by tick().
  logic model_alt  = 1'b0;
  logic model_altv = 1'b0;

  entropy_source_select #(.ALT_LANE(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .src_bit     (src_bit),
    .src_valid   (src_valid),
    .sel         (sel),
    .ent_bit     (ent_bit),
    .ent_valid   (ent_valid),
    .src_changed (src_changed),
    .alt_bit     (alt_bit)
  );

  always #5 clk = ~clk;

  task automatic tick();
    logic r;
    r = rst;
    @(posedge clk);
    if (r) begin
      model_alt  = 1'b0;
      model_altv = 1'b0;
    end else begin
      model_alt  = ~model_alt;
      model_altv = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; sel = 2'd1; src_bit = 4'b0000; src_valid = 4'b0000;
    tick(); tick();
    checks++;
    if (alt_bit !== 1'b0) begin
      errors++; $display("FAIL reset_alt_bit got %b want 0", alt_bit);
    end
    checks++;
    if (src_changed !== 1'b0) begin
      errors++; $display("FAIL reset_src_changed got %b want 0", src_changed);
    end
    checks++;
    if (ent_valid !== 1'b0) begin
      errors++; $display("FAIL reset_ent_valid got %b want 0", ent_valid);
    end
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if (ent_valid !== 1'b1 || ent_bit !== ((i % 2) == 1) || src_changed !== 1'b0) begin
        errors++;
        $display("FAIL alt_edge%0d got v=%b b=%b c=%b want v=1 b=%0d c=0",
                 i, ent_valid, ent_bit, src_changed, (i % 2));
      end
    end
  endtask

  task automatic test_switch();
    sel = 2'd0; src_bit = 4'b0001; src_valid = 4'b0001;
    tick(); tick();
    checks++;
    if (ent_bit !== 1'b1 || ent_valid !== 1'b1 || src_changed !== 1'b0) begin
      errors++;
      $display("FAIL switch_settled got b=%b v=%b c=%b want 1 1 0", ent_bit, ent_valid, src_changed);
    end
    sel = 2'd3; src_bit = 4'b1000; src_valid = 4'b1000;
    #1;
    checks++;
    if (ent_bit !== 1'b1 || ent_valid !== 1'b1) begin
      errors++; $display("FAIL switch_comb got b=%b v=%b want 1 1", ent_bit, ent_valid);
    end
    tick();
    checks++;
    if (ent_bit !== 1'b1 || ent_valid !== 1'b0 || src_changed !== 1'b1) begin
      errors++;
      $display("FAIL switch_pulse got b=%b v=%b c=%b want 1 0 1", ent_bit, ent_valid, src_changed);
    end
    tick();
    checks++;
    if (ent_bit !== 1'b1 || ent_valid !== 1'b1 || src_changed !== 1'b0) begin
      errors++;
      $display("FAIL switch_after got b=%b v=%b c=%b want 1 1 0", ent_bit, ent_valid, src_changed);
    end
  endtask

  task automatic test_hold_sel();
    rst = 1'b1; sel = 2'd2; src_bit = 4'b0100; src_valid = 4'b0100;
    tick();
    checks++;
    if (ent_valid !== 1'b1 || ent_bit !== 1'b1) begin
      errors++; $display("FAIL hold_in_reset got v=%b b=%b want 1 1", ent_valid, ent_bit);
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (src_changed !== 1'b0 || ent_valid !== 1'b1) begin
        errors++; $display("FAIL hold_edge%0d got c=%b v=%b want 0 1", i + 1, src_changed, ent_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    sel = 2'd0; src_bit = 4'b0000; src_valid = 4'b1111;
    tick(); tick();
    for (int s = 1; s <= 3; s++) begin
      sel = 2'(s);
      tick();
      checks++;
      if (src_changed !== 1'b1 || ent_valid !== 1'b0) begin
        errors++; $display("FAIL b2b_step%0d got c=%b v=%b want 1 0", s, src_changed, ent_valid);
      end
    end
    tick();
    checks++;
    if (src_changed !== 1'b0 || ent_valid !== 1'b1) begin
      errors++; $display("FAIL b2b_end got c=%b v=%b want 0 1", src_changed, ent_valid);
    end
  endtask

  task automatic test_glitch();
    sel = 2'd3; tick(); tick();
    sel = 2'd0; #2; sel = 2'd3;
    tick();
    checks++;
    if (src_changed !== 1'b0) begin
      errors++; $display("FAIL glitch got c=%b want 0", src_changed);
    end
  endtask

  task automatic test_reset_mid();
    sel = 2'd3; tick(); tick();
    sel = 2'd0; rst = 1'b1;
    tick();
    checks++;
    if (src_changed !== 1'b0 || alt_bit !== 1'b0) begin
      errors++; $display("FAIL midrst_reset got c=%b a=%b want 0 0", src_changed, alt_bit);
    end
    rst = 1'b0; sel = 2'd2;
    tick();
    checks++;
    if (src_changed !== 1'b0 || alt_bit !== 1'b1) begin
      errors++; $display("FAIL midrst_edge1 got c=%b a=%b want 0 1", src_changed, alt_bit);
    end
    tick();
    checks++;
    if (src_changed !== 1'b0 || alt_bit !== 1'b0) begin
      errors++; $display("FAIL midrst_edge2 got c=%b a=%b want 0 0", src_changed, alt_bit);
    end
  endtask

  task automatic test_alt_override();
    sel = 2'd1; src_bit = 4'b0010; src_valid = 4'b0000;
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      src_bit[1] = i[0];
      #1;
      checks++;
      if (ent_bit !== model_alt || ent_valid !== model_altv || alt_bit !== model_alt) begin
        errors++;
        $display("FAIL alt_override%0d got b=%b v=%b a=%b want b=%b v=%b",
                 i, ent_bit, ent_valid, alt_bit, model_alt, model_altv);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_switch();
    test_hold_sel();
    test_back_to_back();
    test_glitch();
    test_reset_mid();
    test_alt_override();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
